rx_frame_ctrl: RTL and testbench

Sequences the UART receiver's byte stream into fixed-length frames of NUM_BYTES bytes, for example one 4-character message for the 4-digit 7-segment display. It sits between the UART receiver (Rx_DATA/Rx_VALID/Rx_FERROR/Rx_PERROR) and the display/message logic. It publishes a complete frame atomically, and discards a partial frame on any receive error.

---
 rtl/rx_frame_ctrl.sv | 127 ++++++++++++
 tb/tb_rx_frame_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// UART byte stream -> fixed-length frame sequencer with atomic publish and error discard.
// Optional inter-byte idle timeout is compiled in with `define RX_FRAME_TIMEOUT_EN.

module rx_frame_slot #(
  parameter bit IS_LAST = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       pub_en,
  input  logic [7:0] din,
  output logic [7:0] pub_byte
);
  logic [7:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow   <= '0;
      pub_byte <= '0;
    end else begin
      if (wr_en)  shadow   <= din;
      // The final slot publishes the byte arriving on the publish edge.
      if (pub_en) pub_byte <= IS_LAST ? din : shadow;
    end
  end
endmodule

module rx_frame_ctrl #(
  parameter int NUM_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             Rx_DATA,
  input  logic                   Rx_VALID,
  input  logic                   Rx_FERROR,
  input  logic                   Rx_PERROR,
  output logic [8*NUM_BYTES-1:0] frame_data,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic [1:0]             err_code,
  output logic [3:0]             byte_cnt,
  output logic [CNT_W-1:0]       frame_count
);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ERR} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES-1);

  state_t state;
  logic   accept, rx_bad, rx_clean, rx_last, rx_store, tmo_hit;

  // Anything strobed during the error cycle is dropped.
  assign accept   = Rx_VALID && (state != S_ERR);
  assign rx_bad   = accept && (Rx_FERROR || Rx_PERROR);
  assign rx_clean = accept && !Rx_FERROR && !Rx_PERROR;
  assign rx_last  = rx_clean && (byte_cnt == LAST_IDX);
  assign rx_store = rx_clean && !rx_last;

`ifdef RX_FRAME_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES-2);
  logic [TW-1:0] tmo_cnt;

  // Fires on the idle edge that would take the count to TIMEOUT_CYCLES-1.
  assign tmo_hit = (state == S_COLLECT) && !Rx_VALID && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset || state != S_COLLECT || Rx_VALID || tmo_hit) tmo_cnt <= '0;
    else                                                  tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_slot
    rx_frame_slot #(.IS_LAST(k == NUM_BYTES-1)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (rx_store && (byte_cnt == 4'(k))),
      .pub_en   (rx_last),
      .din      (Rx_DATA),
      .pub_byte (frame_data[8*(NUM_BYTES-k)-1 -: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
      byte_cnt    <= '0;
      frame_count <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        S_IDLE, S_COLLECT: begin
          if (rx_bad) begin
            state     <= S_ERR;
            frame_err <= 1'b1;
            err_code  <= Rx_FERROR ? 2'b01 : 2'b10;
            byte_cnt  <= '0;
          end else if (rx_last) begin
            state       <= S_IDLE;
            frame_valid <= 1'b1;
            frame_count <= frame_count + 1'b1;
            byte_cnt    <= '0;
          end else if (rx_clean) begin
            state    <= S_COLLECT;
            byte_cnt <= byte_cnt + 1'b1;
          end else if (tmo_hit) begin
            state     <= S_ERR;
            frame_err <= 1'b1;
            err_code  <= 2'b11;
            byte_cnt  <= '0;
          end
        end
        default: begin
          state    <= S_IDLE;
          byte_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Randomized + directed bench for rx_frame_ctrl against a queue-based frame model.
// Timeout scenarios are exercised when RX_FRAME_TIMEOUT_EN is defined.

module tb_rx_frame_ctrl;
  localparam int N  = 4;
  localparam int T  = 16;
  localparam int CW = 8;
  localparam int VW = 8*N + 8 + CW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     Rx_DATA = '0;
  logic           Rx_VALID = 1'b0, Rx_FERROR = 1'b0, Rx_PERROR = 1'b0;
  logic [8*N-1:0] frame_data;
  logic           frame_valid, frame_err;
  logic [1:0]     err_code;
  logic [3:0]     byte_cnt;
  logic [CW-1:0]  frame_count;

  rx_frame_ctrl #(.NUM_BYTES(N), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
    .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code),
    .byte_cnt(byte_cnt), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference model: bytes of the pending frame in a queue, last published frame, counters.
  logic [7:0]     m_q[$];
  logic [8*N-1:0] m_frame = '0;
  logic [CW-1:0]  m_cnt = '0;
  logic [1:0]     m_code = '0;
  logic           m_valid = 1'b0, m_err = 1'b0, m_drop = 1'b0;
  int             m_idle = 0;
  logic [VW-1:0]  exp_vec = '0;
  logic [VW-1:0]  obs;

  assign obs = {frame_data, frame_valid, frame_err, err_code, byte_cnt, frame_count};

  function automatic void model_step(input logic r, input logic v, input logic [7:0] d,
                                     input logic fe, input logic pe);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_q.delete(); m_frame = '0; m_cnt = '0; m_code = '0; m_drop = 1'b0; m_idle = 0;
    end else if (m_drop) begin
      m_drop = 1'b0; m_idle = 0;
    end else if (v && (fe || pe)) begin
      m_q.delete(); m_err = 1'b1; m_code = fe ? 2'd1 : 2'd2; m_drop = 1'b1; m_idle = 0;
    end else if (v) begin
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == N) begin
        m_frame = '0;
        for (int i = 0; i < N; i++) m_frame = {m_frame[8*N-9:0], m_q[i]};
        m_cnt = m_cnt + 1'b1;
        m_valid = 1'b1;
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
`ifdef RX_FRAME_TIMEOUT_EN
      m_idle++;
      if (m_idle == T-1) begin
        m_q.delete(); m_err = 1'b1; m_code = 2'd3; m_drop = 1'b1; m_idle = 0;
      end
`endif
    end
    exp_vec = {m_frame, m_valid, m_err, m_code, 4'(m_q.size()), m_cnt};
  endfunction

  task automatic tick(input logic r, input logic v, input logic [7:0] d,
                      input logic fe, input logic pe);
    reset = r; Rx_VALID = v; Rx_DATA = d; Rx_FERROR = fe; Rx_PERROR = pe;
    @(posedge clk);
    model_step(r, v, d, fe, pe);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 8'h00, 0, 0);
    tick(1, 1, 8'hFF, 1, 1);
    total++;
    if (obs !== '0) begin
      bad++; $display("FAIL reset_zero: got %h want 0", obs);
    end
    total++;
    if (obs !== exp_vec) begin
      bad++; $display("FAIL reset_model: got %h want %h", obs, exp_vec);
    end
    tick(0, 0, 8'h00, 0, 0);
  endtask

  task automatic test_basic();
    logic [7:0] b [4];
    logic [3:0] bc [4];
    b  = '{8'h41, 8'h42, 8'h43, 8'h44};
    bc = '{4'd1, 4'd2, 4'd3, 4'd0};
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, b[i], 0, 0);
      total++;
      if (byte_cnt !== bc[i]) begin
        bad++; $display("FAIL basic_byte_cnt[%0d]: got %0d want %0d", i, byte_cnt, bc[i]);
      end
      total++;
      if (obs !== exp_vec) begin
        bad++; $display("FAIL basic_model[%0d]: got %h want %h", i, obs, exp_vec);
      end
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          tick(0, 0, 8'h00, 0, 0);
          total++;
          if (frame_valid !== 1'b0 || obs !== exp_vec) begin
            bad++; $display("FAIL basic_gap: got %h want %h", obs, exp_vec);
          end
        end
      end
    end
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'h41424344 || frame_count !== 8'd1) begin
      bad++; $display("FAIL basic_publish: got v=%b d=%h c=%0d want v=1 d=41424344 c=1",
                      frame_valid, frame_data, frame_count);
    end
    tick(0, 0, 8'h00, 0, 0);
    total++;
    if (frame_valid !== 1'b0) begin
      bad++; $display("FAIL basic_pulse_width: got %b want 0", frame_valid);
    end
  endtask

  task automatic test_error();
    tick(0, 1, 8'h11, 0, 0);
    tick(0, 1, 8'h22, 0, 0);
    tick(0, 1, 8'h33, 0, 1);
    total++;
    if (frame_err !== 1'b1 || err_code !== 2'b10 || byte_cnt !== 4'd0 ||
        frame_data !== 32'h41424344 || frame_valid !== 1'b0) begin
      bad++; $display("FAIL parity_err: got e=%b c=%b n=%0d d=%h want e=1 c=10 n=0 d=41424344",
                      frame_err, err_code, byte_cnt, frame_data);
    end
    tick(0, 0, 8'h00, 0, 0);
    total++;
    if (frame_err !== 1'b0 || err_code !== 2'b10 || obs !== exp_vec) begin
      bad++; $display("FAIL parity_err_after: got %h want %h", obs, exp_vec);
    end
    for (int i = 0; i < 4; i++) tick(0, 1, 8'(8'h55 + 8'h11*i), 0, 0);
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'h55667788 || frame_count !== 8'd2) begin
      bad++; $display("FAIL err_recover: got v=%b d=%h c=%0d want v=1 d=55667788 c=2",
                      frame_valid, frame_data, frame_count);
    end
  endtask

  task automatic test_back_to_back();
    tick(1, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      tick(0, 1, 8'(i), 0, 0);
      total++;
      if (obs !== exp_vec) begin
        bad++; $display("FAIL b2b_model[%0d]: got %h want %h", i, obs, exp_vec);
      end
      if (i == 4) begin
        total++;
        if (frame_valid !== 1'b1 || frame_data !== 32'h01020304) begin
          bad++; $display("FAIL b2b_first: got v=%b d=%h want v=1 d=01020304", frame_valid, frame_data);
        end
      end
      if (i == 5) begin
        total++;
        if (byte_cnt !== 4'd1 || frame_valid !== 1'b0) begin
          bad++; $display("FAIL b2b_slot0: got n=%0d v=%b want n=1 v=0", byte_cnt, frame_valid);
        end
      end
    end
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'h05060708 || frame_count !== 8'd2) begin
      bad++; $display("FAIL b2b_second: got v=%b d=%h c=%0d want v=1 d=05060708 c=2",
                      frame_valid, frame_data, frame_count);
    end
  endtask

  task automatic test_reset_midframe();
    tick(0, 0, 8'h00, 0, 0);
    tick(0, 1, 8'h31, 0, 0);
    tick(0, 1, 8'h32, 0, 0);
    tick(1, 0, 8'h00, 0, 0);
    total++;
    if (obs !== '0) begin
      bad++; $display("FAIL midreset_zero: got %h want 0", obs);
    end
    tick(0, 0, 8'h00, 0, 0);
    total++;
    if (frame_err !== 1'b0 || byte_cnt !== 4'd0) begin
      bad++; $display("FAIL midreset_noerr: got e=%b n=%0d want e=0 n=0", frame_err, byte_cnt);
    end
    for (int i = 0; i < 4; i++) tick(0, 1, 8'(8'hA1 + i), 0, 0);
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'hA1A2A3A4 || frame_count !== 8'd1) begin
      bad++; $display("FAIL midreset_frame: got v=%b d=%h c=%0d want v=1 d=A1A2A3A4 c=1",
                      frame_valid, frame_data, frame_count);
    end
  endtask

  task automatic test_both_err_drop();
    tick(0, 0, 8'h00, 0, 0);
    tick(0, 1, 8'h99, 1, 1);
    total++;
    if (frame_err !== 1'b1 || err_code !== 2'b01) begin
      bad++; $display("FAIL ferr_priority: got e=%b c=%b want e=1 c=01", frame_err, err_code);
    end
    tick(0, 1, 8'h5A, 0, 0);
    total++;
    if (byte_cnt !== 4'd0 || frame_err !== 1'b0 || frame_valid !== 1'b0) begin
      bad++; $display("FAIL err_cycle_drop: got n=%0d e=%b v=%b want n=0 e=0 v=0",
                      byte_cnt, frame_err, frame_valid);
    end
    tick(0, 0, 8'h00, 1, 1);
    total++;
    if (byte_cnt !== 4'd0 || frame_err !== 1'b0 || obs !== exp_vec) begin
      bad++; $display("FAIL err_ignored_novalid: got %h want %h", obs, exp_vec);
    end
  endtask

  task automatic test_timeout();
    tick(1, 0, 8'h00, 0, 0);
    tick(0, 1, 8'h10, 0, 0);
`ifdef RX_FRAME_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      tick(0, 0, 8'h00, 0, 0);
      total++;
      if (frame_err !== (k == 15) || obs !== exp_vec) begin
        bad++; $display("FAIL timeout_k%0d: got e=%b %h want e=%b %h", k, frame_err, obs, k == 15, exp_vec);
      end
      if (k == 15) begin
        total++;
        if (err_code !== 2'b11 || byte_cnt !== 4'd0) begin
          bad++; $display("FAIL timeout_code: got c=%b n=%0d want c=11 n=0", err_code, byte_cnt);
        end
      end
    end
    tick(1, 0, 8'h00, 0, 0);
    tick(0, 1, 8'h10, 0, 0);
    for (int k = 1; k <= 14; k++) tick(0, 0, 8'h00, 0, 0);
    tick(0, 1, 8'h20, 0, 0);
    total++;
    if (frame_err !== 1'b0 || byte_cnt !== 4'd2) begin
      bad++; $display("FAIL timeout_edge_byte: got e=%b n=%0d want e=0 n=2", frame_err, byte_cnt);
    end
    for (int k = 1; k <= 14; k++) begin
      tick(0, 0, 8'h00, 0, 0);
      total++;
      if (frame_err !== 1'b0 || obs !== exp_vec) begin
        bad++; $display("FAIL timeout_restart_k%0d: got %h want %h", k, obs, exp_vec);
      end
    end
`else
    for (int k = 1; k <= 40; k++) begin
      tick(0, 0, 8'h00, 0, 0);
      total++;
      if (frame_err !== 1'b0 || byte_cnt !== 4'd1) begin
        bad++; $display("FAIL no_timeout_k%0d: got e=%b n=%0d want e=0 n=1", k, frame_err, byte_cnt);
      end
    end
`endif
    tick(0, 1, 8'h30, 0, 0);
    tick(0, 1, 8'h40, 0, 0);
    tick(0, 1, 8'h50, 0, 0);
    total++;
    if (obs !== exp_vec) begin
      bad++; $display("FAIL timeout_tail: got %h want %h", obs, exp_vec);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      logic r, v, fe, pe;
      logic [7:0] d;
      int e;
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 9) < 4);
      d  = 8'($urandom);
      e  = $urandom_range(0, 23);
      fe = (e == 0) || (e == 2);
      pe = (e == 1) || (e == 2);
      tick(r, v, d, fe, pe);
      total++;
      if (obs !== exp_vec) begin
        bad++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec);
      end
      if ($urandom_range(0, 149) == 0) begin
        for (int g = 0; g < 18; g++) begin
          tick(0, 0, 8'h00, 0, 0);
          total++;
          if (obs !== exp_vec) begin
            bad++; $display("FAIL random_idle[%0d]: got %h want %h", i, obs, exp_vec);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_back_to_back();
    test_reset_midframe();
    test_both_err_drop();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
